// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the APB4 requester.
//   apb_state_t : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb_resp_t  : completion codes reported on rsp_err
//   idx_width() : width of the slave index field (at least 1 bit)
//   cnt_width() : width of the timeout counter (at least 1 bit)
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef enum logic [1:0] {
    RESP_OKAY    = 2'd0,
    RESP_SLVERR  = 2'd1,
    RESP_TIMEOUT = 2'd2,
    RESP_DECERR  = 2'd3
  } apb_resp_t;

  // A single slave still needs a 1-bit index so that ports keep a legal width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // TIMEOUT = 0 disables the timeout; keep a 1-bit dummy counter in that case.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: combinational slave decoder.
//   i_addr  in  ADDR_W   command byte address
//   o_idx   out IDX_W    slave index taken from i_addr[SLV_LSB +: IDX_W] (0 for one slave)
//   o_sel   out NUM_SLV  one-hot select, all zero when out of range
//   o_oor   out 1        index is not a populated slave (non-power-of-two NUM_SLV)
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  localparam int IDX_W  = idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_SLV-1:0] o_sel,
  output logic               o_oor
);

  // One extra bit so NUM_SLV itself is representable (e.g. 16 with a 4-bit index).
  localparam logic [IDX_W:0] NUM_SLV_V = (IDX_W + 1)'(NUM_SLV);

  logic [IDX_W-1:0] w_idx;

  generate
    if (NUM_SLV > 1) begin : g_multi
      assign w_idx = i_addr[SLV_LSB +: IDX_W];
    end else begin : g_single
      assign w_idx = '0;
    end
  endgenerate

  assign o_idx = w_idx;
  assign o_oor = ({1'b0, w_idx} >= NUM_SLV_V);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign o_sel[gi] = !o_oor && (w_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB4 requester with command/response valid-ready ports.
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/strb/prot  command fields
//   rsp_valid/rsp_ready     completion handshake
//   rsp_rdata/rsp_err       read data (0 for writes/errors), response code
//   PADDR..PPROT            APB requester outputs, NUM_SLV one-hot PSEL
//   PRDATA/PREADY/PSLVERR   per-slave completer inputs
// All APB outputs come from registers or decode of the registered state, so
// there is no combinational path from PREADY to the bus.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [DATA_W/8-1:0]       cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [2:0]                PPROT,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W  = idx_width(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam bit TO_EN  = (TIMEOUT != 0);
  // Abort fires in the ACCESS cycle whose count (before increment) is TIMEOUT-1,
  // i.e. on the TIMEOUT-th ACCESS cycle without PREADY.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_t          r_state;
  apb_state_t          w_state_next;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [2:0]          r_pprot;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_SLV-1:0]  r_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rsp_rdata;
  apb_resp_t           r_rsp_err;

  logic [IDX_W-1:0]    w_dec_idx;
  logic [NUM_SLV-1:0]  w_dec_sel;
  logic                w_dec_oor;
  logic                w_hs;
  logic                w_pready;
  logic                w_pslverr;
  logic [DATA_W-1:0]   w_prdata;
  logic                w_timeout_hit;

  apb_slv_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SLV_LSB (SLV_LSB)
  ) u_decode (
    .i_addr (cmd_addr),
    .o_idx  (w_dec_idx),
    .o_sel  (w_dec_sel),
    .o_oor  (w_dec_oor)
  );

  assign w_hs = cmd_valid && (r_state == IDLE);

  // Only the selected slave's handshake signals count; r_sel is one-hot.
  assign w_pready  = |(PREADY  & r_sel);
  assign w_pslverr = |(PSLVERR & r_sel);

  always_comb begin
    w_prdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_prdata = PRDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_timeout_hit = TO_EN && (r_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; PREADY has priority over a simultaneous timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_state_next = w_dec_oor ? RESP : SETUP;
        end
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (w_pready || w_timeout_hit) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Command capture, timeout counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_idx       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= RESP_OKAY;
    end else begin
      if (w_hs) begin
        // Bus fields only change here, so they hold across the whole
        // transfer and keep their last values afterwards.
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
        r_pstrb  <= cmd_write ? cmd_strb  : '0;
        r_pprot  <= cmd_prot;
        r_idx    <= w_dec_idx;
        r_sel    <= w_dec_sel;
        r_cnt    <= '0;
        if (w_dec_oor) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= RESP_DECERR;
        end
      end

      if (r_state == ACCESS) begin
        if (w_pready) begin
          r_rsp_err   <= w_pslverr ? RESP_SLVERR : RESP_OKAY;
          r_rsp_rdata <= (!r_pwrite && !w_pslverr) ? w_prdata : '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout_hit) begin
            r_rsp_err   <= RESP_TIMEOUT;
            r_rsp_rdata <= '0;
          end
        end
      end
    end
  end

  // Outputs decoded from registered state
  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel : '0;
  assign PENABLE   = (r_state == ACCESS);
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed, table-driven bench for apb_master_ctrl.
// Instance u_dut: 4 slaves, TIMEOUT=8. Instance u_dut3: 3 slaves (decode error).
module tb_apb_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT A (4 slaves, TIMEOUT=8) ----------------
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_strb;
  logic [2:0]   cmd_prot;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_rdata;
  logic [1:0]   rsp_err;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   psel, pstrb, pready, pslverr;
  logic         penable, pwrite;
  logic [2:0]   pprot;
  logic [127:0] prdata;

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_LSB(12), .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
    .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  // ---------------- DUT B (3 slaves) ----------------
  logic         b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [31:0]  b_cmd_addr, b_cmd_wdata;
  logic [3:0]   b_cmd_strb;
  logic [2:0]   b_cmd_prot;
  logic         b_rsp_valid, b_rsp_ready;
  logic [31:0]  b_rsp_rdata;
  logic [1:0]   b_rsp_err;
  logic [31:0]  b_paddr, b_pwdata;
  logic [2:0]   b_psel, b_pready, b_pslverr;
  logic [3:0]   b_pstrb;
  logic         b_penable, b_pwrite;
  logic [2:0]   b_pprot;
  logic [95:0]  b_prdata;

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_LSB(12), .TIMEOUT(0)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_strb(b_cmd_strb), .cmd_prot(b_cmd_prot),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PADDR(b_paddr), .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PWDATA(b_pwdata),
    .PSTRB(b_pstrb), .PPROT(b_pprot), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          ws;         // wait states before PREADY; large = never ready
    logic        slverr;
    logic [31:0] sdata;      // selected slave's PRDATA
    logic [3:0]  exp_psel;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;    // expected ACCESS cycles
  } vec_t;

  vec_t vecs [7];
  vec_t vpost;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Unselected slaves are always ready with an error and junk data.
  task automatic set_bg(input int slv, input logic [31:0] sdata);
    for (int k = 0; k < 4; k++) begin
      pready[k]  = 1'b1;
      pslverr[k] = 1'b1;
      prdata[k*32 +: 32] = 32'hF0F0_0000 | 32'(k);
    end
    pready[slv]  = 1'b0;
    prdata[slv*32 +: 32] = sdata;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int slv;
    int n;
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    slv    = int'(v.addr[13:12]);
    exp_wd = v.wr ? v.wdata : 32'h0;
    exp_st = v.wr ? v.strb : 4'h0;
    @(negedge clk);
    set_bg(slv, v.sdata);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, " setup_psel"}, 32'(psel), 32'(v.exp_psel));
    chk({tag, " setup_penable"}, 32'(penable), 32'h0);
    chk({tag, " setup_paddr"}, paddr, v.addr);
    chk({tag, " setup_pwrite"}, 32'(pwrite), 32'(v.wr));
    chk({tag, " setup_pwdata"}, pwdata, exp_wd);
    chk({tag, " setup_pstrb"}, 32'(pstrb), 32'(exp_st));
    chk({tag, " setup_pprot"}, 32'(pprot), 32'(v.prot));
    n = 0;
    @(negedge clk);
    while (penable === 1'b1 && n < 40) begin
      chk({tag, " access_psel"}, 32'(psel), 32'(v.exp_psel));
      chk({tag, " access_paddr"}, paddr, v.addr);
      chk({tag, " access_pstrb"}, 32'(pstrb), 32'(exp_st));
      pready[slv]  = (n == v.ws);
      pslverr[slv] = (n == v.ws) ? v.slverr : 1'b1;
      n++;
      @(negedge clk);
    end
    pready[slv] = 1'b0;
    chk({tag, " access_cycles"}, 32'(n), 32'(v.exp_acc));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " resp_psel"}, 32'(psel), 32'h0);
    chk({tag, " resp_penable"}, 32'(penable), 32'h0);
    chk({tag, " resp_cmd_ready"}, 32'(cmd_ready), 32'h0);
    chk({tag, " hold_paddr"}, paddr, v.addr);
    $display("txn %s wr=%0d addr=%h acc=%0d err=%0d rdata=%h", tag, v.wr, v.addr, n, rsp_err, rsp_rdata);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " done_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, " done_cmd_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    //           wr    addr          wdata         strb  prot  ws    err   sdata         psel     err   rdata         acc
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,    1'b0, 32'h1111_1111, 4'b0010, 2'd0, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h0000_2010, 32'hAAAA_5555, 4'hF, 3'd2, 3,    1'b0, 32'h1234_5678, 4'b0100, 2'd0, 32'h1234_5678, 4};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 3'd1, 0,    1'b1, 32'hCAFE_F00D, 4'b0001, 2'd1, 32'h0,         1};
    vecs[3] = '{1'b0, 32'h0000_3000, 32'h0,         4'h0, 3'd0, 1000, 1'b0, 32'hFEED_FACE, 4'b1000, 2'd2, 32'h0,         8};
    vecs[4] = '{1'b0, 32'h0000_3004, 32'h0,         4'h0, 3'd0, 7,    1'b0, 32'h0BAD_F00D, 4'b1000, 2'd0, 32'h0BAD_F00D, 8};
    vecs[5] = '{1'b1, 32'h0000_1FFC, 32'h0102_0304, 4'h5, 3'd5, 2,    1'b1, 32'h7777_7777, 4'b0010, 2'd1, 32'h0,         3};
    vecs[6] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 3'd3, 1,    1'b0, 32'h55AA_33CC, 4'b0001, 2'd0, 32'h55AA_33CC, 2};
    vpost   = '{1'b1, 32'h0000_2040, 32'hA5A5_0F0F, 4'hC, 3'd6, 0,    1'b0, 32'h0,         4'b0100, 2'd0, 32'h0,         1};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    rsp_ready = 1'b0; pready = '0; pslverr = '0; prdata = '0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_strb = '0;
    b_cmd_prot = '0; b_rsp_ready = 1'b0; b_pready = 3'b111; b_pslverr = 3'b000;
    b_prdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    // Reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of ACCESS abandons the transfer.
    @(negedge clk);
    set_bg(2, 32'h9999_9999);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_2ABC;
    cmd_wdata = 32'h1357_9BDF; cmd_strb = 4'hF; cmd_prot = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_access", 32'(penable), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(psel), 32'h0);
    chk("mid_rst_penable", 32'(penable), 32'h0);
    chk("mid_rst_paddr", paddr, 32'h0);
    chk("mid_rst_pwrite", 32'(pwrite), 32'h0);
    chk("mid_rst_pwdata", pwdata, 32'h0);
    chk("mid_rst_pstrb", 32'(pstrb), 32'h0);
    chk("mid_rst_pprot", 32'(pprot), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_rst_psel", 32'(psel), 32'h0);
    chk("in_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_psel", 32'(psel), 32'h0);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    $display("txn reset_mid_access abandoned");
    run_vec(vpost, "post_rst");

    // Decode error on the 3-slave instance, with 5 cycles of backpressure.
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 32'h0000_3008;
    chk("dec_cmd_ready", 32'(b_cmd_ready), 32'h1);
    @(negedge clk);
    b_cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("dec_rsp_valid_c%0d", c), 32'(b_rsp_valid), 32'h1);
      chk($sformatf("dec_rsp_err_c%0d", c), 32'(b_rsp_err), 32'h3);
      chk($sformatf("dec_rsp_rdata_c%0d", c), b_rsp_rdata, 32'h0);
      chk($sformatf("dec_psel_c%0d", c), 32'(b_psel), 32'h0);
      chk($sformatf("dec_penable_c%0d", c), 32'(b_penable), 32'h0);
      chk($sformatf("dec_cmd_ready_c%0d", c), 32'(b_cmd_ready), 32'h0);
      if (c < 5) @(negedge clk);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    chk("dec_done_cmd_ready", 32'(b_cmd_ready), 32'h1);
    chk("dec_done_rsp_valid", 32'(b_rsp_valid), 32'h0);
    $display("txn decerr addr=%h err=%0d", b_cmd_addr, b_rsp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB4 requester: accepts single read/write commands on a valid/ready command port and returns completions on a valid/ready response port. Drives NUM_SLV decoded PSEL lines with PSTRB/PPROT, sampling PREADY/PSLVERR per slave. Adds a per-transfer timeout and decode-error reporting. Sits between the system command fabric or bench-side sequencer and the peripheral APB segment.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- NUM_SLV, 4, number of slaves, 1..16.
- SLV_LSB, 12, lowest address bit of the slave index field. Index = cmd_addr[SLV_LSB +: $clog2(NUM_SLV)], or 0 when NUM_SLV=1.
- TIMEOUT, 256, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  completion present.
- rsp_ready  in  1  completion consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  2  response code: 0 OKAY, 1 SLVERR, 2 TIMEOUT, 3 DECERR.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  NUM_SLV  one-hot select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PWDATA  out  DATA_W  write data.
- PSTRB  out  DATA_W/8  byte strobes.
- PPROT  out  3  protection.
- PRDATA  in  NUM_SLV*DATA_W  slave k occupies bits [k*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE).
- **IDLE:** On handshake, register addr/write/wdata/strb/prot and the decoded index.
  - Index < NUM_SLV → SETUP.
  - Index ≥ NUM_SLV (non-power-of-two NUM_SLV only) → RESP with DECERR. No PSEL is asserted.
- **SETUP:** PSEL[idx]=1, PENABLE=0. Always exactly one cycle, then ACCESS.
- **ACCESS:** PSEL[idx]=1, PENABLE=1.
  - PREADY[idx]=1 → RESP. Capture PRDATA slice (reads only) and PSLVERR[idx]; rsp_err = SLVERR ? 1 : 0.
  - When PSLVERR is set, rsp_rdata = 0.
  - PREADY, PSLVERR and PRDATA of unselected slaves are ignored.
- **Timeout:** Counter clears on entry to SETUP and increments each ACCESS cycle without PREADY. When it reaches TIMEOUT → RESP with err=2 and rdata=0; PSEL/PENABLE drop on the next edge. Counter width is $clog2(TIMEOUT+1).
- **RESP:** rsp_valid=1 with stable rdata/err until rsp_ready, then IDLE. PSEL=0, PENABLE=0.
- **Reads:** PWDATA=0 and PSTRB=0.
- **Bus hold:** PADDR, PWRITE, PPROT, PWDATA and PSTRB are constant from SETUP through the last ACCESS cycle. After the transfer they hold their last values until the next command.
- **Reset (async):** All of the following go to 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, counter. State → IDLE.
  - Reset mid-transfer abandons the transfer with no response.
  - cmd_ready reads 1 during reset, but no command is accepted while rst_n is low.

## Timing
- Command accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- PREADY high in cycle 2 → rsp_valid in cycle 3.
- With rsp_ready high, cmd_ready is high in cycle 4. Minimum throughput is 4 cycles per transfer.
- Each wait state adds one cycle.
- DECERR: rsp_valid appears the cycle after the handshake.
- TIMEOUT=N: rsp_valid appears N+2 cycles after the handshake, i.e. after N ACCESS cycles.
- PREADY arriving in the same cycle the counter hits TIMEOUT: PREADY wins and the response is normal.
- Outputs are registered or decoded from registered state only. There is no combinational path from PREADY to any APB output.

## Structure
- Package apb_pkg holds:
  - typedef apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - typedef apb_resp_t with constants RESP_OKAY, RESP_SLVERR, RESP_TIMEOUT, RESP_DECERR.
- Sub-module apb_slv_decode, combinational, parametrised by ADDR_W/NUM_SLV/SLV_LSB. Outputs: index, one-hot select, and an out-of-range flag.
- FSM, timeout counter and capture registers live in apb_master_ctrl.

## Test plan
- **Write, zero wait:** write 0x0000_1004 ← 0xDEADBEEF, strb 0xF, slave 1 PREADY immediate. Expect PSEL=4'b0010, SETUP then one ACCESS cycle, PSTRB=0xF, rsp_err=0 in cycle 3.
- **Read, 3 wait states:** read 0x0000_2010; slave 2 returns 0x1234_5678 after 3 wait states. Expect rsp_rdata=0x1234_5678, err=0, address stable throughout, PSTRB=0.
- **SLVERR:** slave 0 asserts PREADY with PSLVERR on a read. Expect err=1, rdata=0.
- **Timeout:** TIMEOUT=8, slave 3 never ready. Expect exactly 8 ACCESS cycles, then PSEL low, err=2, rdata=0. Also: PREADY on cycle 8 must give err=0.
- **Decode error and backpressure:** NUM_SLV=3, address index 3. Expect no PSEL and err=3. Hold rsp_ready=0 for 5 cycles; response must stay stable and cmd_ready low.
- **Reset mid-ACCESS:** assert rst_n low mid-ACCESS. All outputs go to 0 immediately, and the next command completes normally.
